// File: rtl/cart_mapper_detect.sv
// Heuristic ROM mapper detector: counts LD (nnnn),A bank-select writes in a
// loading ROM image and classifies the mapper once the last byte is seen.
module cart_mapper_detect #(
   parameter logic [23:0] SMALL_ROM_MAX = 24'h010000,
   parameter int          CNT_W         = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       data_valid,
   input  logic [7:0] data,
   input  logic       last,
   output logic       busy,
   output logic       done,
   output logic [5:0] mapper,
   output logic [2:0] cart_type
);

   localparam logic [5:0] MAPPER_NO_UNKNOWN = 6'd0;
   localparam logic [5:0] MAPPER_LINEAR     = 6'd1;
   localparam logic [5:0] MAPPER_KONAMI     = 6'd2;
   localparam logic [5:0] MAPPER_KONAMI_SCC = 6'd3;
   localparam logic [5:0] MAPPER_ASCII8     = 6'd4;
   localparam logic [5:0] MAPPER_ASCII16    = 6'd5;
   localparam logic [2:0] CART_TYPE_ROM     = 3'd1;
   localparam int         SW                = CNT_W + 2;

   // Counter slots: 0=5000 1=6000 2=6800 3=7000 4=7800 5=77FF 6=8000 7=9000 8=A000 9=B000
   localparam logic [15:0] HIT_ADDR [10] = '{16'h5000, 16'h6000, 16'h6800, 16'h7000,
                                             16'h7800, 16'h77FF, 16'h8000, 16'h9000,
                                             16'hA000, 16'hB000};

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SUM, S_DECIDE} state_t;
   typedef enum logic [1:0] {P_SEEK, P_LO, P_HI} pstate_t;

   state_t          r_state;
   pstate_t         r_pstate;
   logic [7:0]      r_lo;
   logic [23:0]     r_bytes;
   logic [SW-1:0]   r_konami, r_scc, r_ascii8, r_ascii16;

   logic                w_accept;
   logic                w_phi_accept;
   logic [15:0]         w_addr;
   logic [CNT_W-1:0]    w_cnt [10];
   logic [SW-1:0]       w_best;
   logic [5:0]          w_mapper;

   assign w_accept     = data_valid && (r_state == S_SCAN) && !start;
   assign w_phi_accept = w_accept && (r_pstate == P_HI);
   assign w_addr       = {data, r_lo};

   genvar gi;
   generate
      for (gi = 0; gi < 10; gi++) begin : g_hit
         logic [CNT_W-1:0] r_cnt;
         always_ff @(posedge clk) begin
            if (!reset_n || start)
               r_cnt <= '0;
            else if (w_phi_accept && (w_addr == HIT_ADDR[gi]) && (r_cnt != {CNT_W{1'b1}}))
               r_cnt <= r_cnt + CNT_W'(1);
         end
         assign w_cnt[gi] = r_cnt;
      end
   endgenerate

   // Strict '>' keeps the earlier (higher-priority) candidate on ties.
   always_comb begin
      w_best   = r_scc;
      w_mapper = MAPPER_KONAMI_SCC;
      if (r_konami > w_best) begin
         w_best   = r_konami;
         w_mapper = MAPPER_KONAMI;
      end
      if (r_ascii8 > w_best) begin
         w_best   = r_ascii8;
         w_mapper = MAPPER_ASCII8;
      end
      if (r_ascii16 > w_best) begin
         w_best   = r_ascii16;
         w_mapper = MAPPER_ASCII16;
      end
      if (w_best == '0)
         w_mapper = MAPPER_NO_UNKNOWN;
      if (r_bytes <= SMALL_ROM_MAX)
         w_mapper = MAPPER_LINEAR;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_pstate  <= P_SEEK;
         r_lo      <= '0;
         r_bytes   <= '0;
         r_konami  <= '0;
         r_scc     <= '0;
         r_ascii8  <= '0;
         r_ascii16 <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mapper    <= MAPPER_NO_UNKNOWN;
         cart_type <= CART_TYPE_ROM;
      end else if (start) begin
         r_state  <= S_SCAN;
         r_pstate <= P_SEEK;
         r_bytes  <= '0;
         busy     <= 1'b1;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_SCAN: begin
               if (data_valid) begin
                  if (r_bytes != 24'hFFFFFF)
                     r_bytes <= r_bytes + 24'd1;
                  case (r_pstate)
                     P_SEEK:  if (data == 8'h32) r_pstate <= P_LO;
                     P_LO: begin
                        r_lo     <= data;
                        r_pstate <= P_HI;
                     end
                     default: r_pstate <= P_SEEK;
                  endcase
                  if (last) begin
                     r_pstate <= P_SEEK;
                     r_state  <= S_SUM;
                  end
               end
            end
            S_SUM: begin
               r_konami  <= SW'(w_cnt[1]) + SW'(w_cnt[6]) + SW'(w_cnt[8]);
               r_scc     <= SW'(w_cnt[0]) + SW'(w_cnt[7]) + SW'(w_cnt[9]);
               r_ascii8  <= SW'(w_cnt[1]) + SW'(w_cnt[2]) + SW'(w_cnt[3]) + SW'(w_cnt[4]);
               r_ascii16 <= SW'(w_cnt[1]) + SW'(w_cnt[3]) + SW'(w_cnt[5]);
               r_state   <= S_DECIDE;
            end
            S_DECIDE: begin
               mapper    <= w_mapper;
               cart_type <= CART_TYPE_ROM;
               done      <= 1'b1;
               busy      <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cart_mapper_detect.sv
// Directed and randomized image streams for cart_mapper_detect, checked
// against a byte-level reference classifier.
module tb_cart_mapper_detect;

   localparam logic [23:0] SMALL = 24'd1024;
   localparam int          CMAX  = 255;

   localparam logic [5:0] M_NONE   = 6'd0;
   localparam logic [5:0] M_LINEAR = 6'd1;
   localparam logic [5:0] M_KONAMI = 6'd2;
   localparam logic [5:0] M_KSCC   = 6'd3;
   localparam logic [5:0] M_ASCII8 = 6'd4;
   localparam logic [5:0] M_ASC16  = 6'd5;
   localparam logic [2:0] CT_ROM   = 3'd1;

   localparam logic [15:0] ADDRS [10] = '{16'h5000, 16'h6000, 16'h6800, 16'h7000,
                                          16'h7800, 16'h77FF, 16'h8000, 16'h9000,
                                          16'hA000, 16'hB000};

   logic       clk = 1'b0;
   logic       reset_n, start, data_valid, last;
   logic [7:0] data;
   logic       busy, done;
   logic [5:0] mapper;
   logic [2:0] cart_type;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] stim[$];

   cart_mapper_detect #(.SMALL_ROM_MAX(SMALL), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .data_valid(data_valid),
      .data(data), .last(last), .busy(busy), .done(done),
      .mapper(mapper), .cart_type(cart_type)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference classifier working directly on the byte list.
   function automatic logic [5:0] model();
      int cnt [10];
      int n, i, konami, scc, a8, a16, best;
      logic [15:0] a;
      n = stim.size();
      for (int j = 0; j < 10; j++) cnt[j] = 0;
      i = 0;
      while (i < n) begin
         if (stim[i] == 8'h32) begin
            if (i + 2 < n) begin
               a = {stim[i+2], stim[i+1]};
               for (int j = 0; j < 10; j++)
                  if (a == ADDRS[j] && cnt[j] < CMAX) cnt[j]++;
            end
            i += 3;
         end else begin
            i++;
         end
      end
      konami = cnt[1] + cnt[6] + cnt[8];
      scc    = cnt[0] + cnt[7] + cnt[9];
      a8     = cnt[1] + cnt[2] + cnt[3] + cnt[4];
      a16    = cnt[1] + cnt[3] + cnt[5];
      if (n <= int'(SMALL)) return M_LINEAR;
      best = konami;
      if (scc > best) best = scc;
      if (a8 > best)  best = a8;
      if (a16 > best) best = a16;
      if (best == 0)       return M_NONE;
      if (scc == best)     return M_KSCC;
      if (konami == best)  return M_KONAMI;
      if (a8 == best)      return M_ASCII8;
      return M_ASC16;
   endfunction

   function automatic logic [7:0] filler();
      logic [7:0] b;
      do b = 8'($urandom); while (b == 8'h32);
      return b;
   endfunction

   task automatic add_pat(input logic [15:0] a, input int reps);
      repeat (reps) begin
         repeat ($urandom_range(0, 3)) stim.push_back(filler());
         stim.push_back(8'h32);
         stim.push_back(a[7:0]);
         stim.push_back(a[15:8]);
      end
   endtask

   task automatic pad_to(input int n);
      while (stim.size() < n) stim.push_back(filler());
   endtask

   task automatic build_random(input int n);
      logic [15:0] a;
      stim.delete();
      while (stim.size() < n) begin
         if ($urandom_range(0, 3) == 0) begin
            a = ($urandom_range(0, 4) != 0) ? ADDRS[$urandom_range(0, 9)] : 16'($urandom);
            stim.push_back(8'h32);
            stim.push_back(a[7:0]);
            stim.push_back(a[15:8]);
         end else begin
            stim.push_back(8'($urandom));
         end
      end
      while (stim.size() > n) void'(stim.pop_back());
   endtask

   task automatic pulse_start(input bit with_byte);
      @(negedge clk);
      start      = 1'b1;
      data_valid = with_byte;
      data       = 8'h32;
      last       = with_byte;
      @(negedge clk);
      start      = 1'b0;
      data_valid = 1'b0;
      last       = 1'b0;
      check("busy_after_start", busy, 1);
      check("done_after_start", done, 0);
   endtask

   task automatic feed(input int n, input bit gaps, input bit use_last);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 7) == 0) begin
            data_valid = 1'b0;
            data       = 8'h32;
            last       = 1'b1;
            @(negedge clk);
         end
         data_valid = 1'b1;
         data       = stim[i];
         last       = use_last && (i == n - 1);
         @(negedge clk);
      end
      data_valid = 1'b0;
      last       = 1'b0;
   endtask

   task automatic run_image(input string tag, input bit gaps);
      logic [5:0] exp;
      exp = model();
      feed(stim.size(), gaps, 1'b1);
      data_valid = 1'b1;
      data       = 8'h32;
      last       = 1'b1;
      check({tag, "_done_n0"}, done, 0);
      @(negedge clk);
      check({tag, "_done_n1"}, done, 0);
      check({tag, "_busy_n1"}, busy, 1);
      @(negedge clk);
      check({tag, "_done_n2"}, done, 1);
      check({tag, "_busy_n2"}, busy, 0);
      check({tag, "_mapper"}, mapper, exp);
      check({tag, "_cart_type"}, cart_type, CT_ROM);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_mapper_hold"}, mapper, exp);
      repeat (2) @(negedge clk);
      check({tag, "_no_extra_done"}, done, 0);
      data_valid = 1'b0;
      last       = 1'b0;
      $display("image %s: len %0d mapper %0d expected %0d", tag, stim.size(), mapper, exp);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; data_valid = 1'b0; data = '0; last = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mapper", mapper, M_NONE);
      check("rst_cart_type", cart_type, CT_ROM);
      reset_n = 1'b1;

      stim.delete(); pad_to(600);
      pulse_start(0); run_image("linear", 1);

      stim.delete(); add_pat(16'h8000, 5); pad_to(int'(SMALL));
      pulse_start(0); run_image("len_eq_max", 0);

      stim.delete(); pad_to(int'(SMALL) + 1);
      pulse_start(0); run_image("len_max_plus1", 0);

      stim.delete(); add_pat(16'h5000, 5); add_pat(16'h9000, 5); add_pat(16'hB000, 5); pad_to(2048);
      pulse_start(0); run_image("scc", 1);

      stim.delete(); add_pat(16'h6800, 4); add_pat(16'h7800, 4); add_pat(16'h6000, 2); pad_to(2048);
      pulse_start(0); run_image("ascii8", 1);

      stim.delete(); add_pat(16'h6000, 3); add_pat(16'h7000, 3);
      stim.push_back(8'h32); stim.push_back(8'h32); stim.push_back(8'h00); stim.push_back(8'h80);
      pad_to(2048);
      pulse_start(0); run_image("tie_operand", 0);

      stim.delete(); add_pat(16'h8000, 300); pad_to(2048);
      pulse_start(0); run_image("saturate", 1);

      stim.delete(); pad_to(2048);
      pulse_start(0); run_image("no_hits", 1);

      stim.delete(); add_pat(16'h9000, 2); pad_to(1500); stim.push_back(8'h32); stim.push_back(8'h00);
      pulse_start(0); run_image("trailing_partial", 0);

      stim.delete(); stim.push_back(8'hB0); add_pat(16'h8000, 1); pad_to(1500);
      pulse_start(0); run_image("after_partial", 0);

      for (int r = 0; r < 4; r++) begin
         build_random($urandom_range(1100, 2000));
         pulse_start(0); run_image($sformatf("random%0d", r), 1);
      end

      // Reset mid-scan: outputs revert and the aborted image never completes.
      stim.delete(); add_pat(16'h7000, 20); pad_to(1500);
      pulse_start(0);
      feed(700, 1, 0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_mapper", mapper, M_NONE);
      check("midrst_cart_type", cart_type, CT_ROM);
      feed(200, 0, 1);
      for (int k = 0; k < 4; k++) begin
         check("midrst_no_done", done, 0);
         @(negedge clk);
      end
      $display("image midscan_reset: mapper %0d busy %0d", mapper, busy);

      // Restart mid-scan: nothing from the aborted image may leak.
      stim.delete(); add_pat(16'h8000, 300); pad_to(1500);
      pulse_start(0);
      feed(1200, 1, 0);
      stim.delete(); pad_to(600);
      pulse_start(1); run_image("abort_small", 1);

      stim.delete(); add_pat(16'h5000, 100); pad_to(1500);
      pulse_start(0);
      feed(1200, 1, 0);
      stim.delete(); pad_to(2048);
      pulse_start(1); run_image("abort_large", 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
